// File: rtl/vga_pattern_pkg.sv
// Shared constants for the VGA test-pattern source: palette, mode codes,
// pixel payload type and common widths.
package vga_pattern_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned MODE_W = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [PIX_W-1:0] PAL_BLACK  = 24'h000000;
  localparam logic [PIX_W-1:0] PAL_BLUE   = 24'h0000FF;
  localparam logic [PIX_W-1:0] PAL_RED    = 24'hFF0000;
  localparam logic [PIX_W-1:0] PAL_PURPLE = 24'hFF00FF;
  localparam logic [PIX_W-1:0] PAL_GREEN  = 24'h00FF00;
  localparam logic [PIX_W-1:0] PAL_CYAN   = 24'h00FFFF;
  localparam logic [PIX_W-1:0] PAL_YELLOW = 24'hFFFF00;
  localparam logic [PIX_W-1:0] PAL_WHITE  = 24'hFFFFFF;

  localparam logic [PIX_W-1:0] BLACK = PAL_BLACK;
  localparam logic [PIX_W-1:0] WHITE = PAL_WHITE;
  localparam logic [PIX_W-1:0] BLUE  = PAL_BLUE;

  localparam logic [MODE_W-1:0] MODE_GRID = 2'd0;
  localparam logic [MODE_W-1:0] MODE_CHK  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_RAMP = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BOX  = 2'd3;

  typedef enum logic {DIR_INC, DIR_DEC} dir_e;

  // Palette lookup for grid cells.
  function automatic logic [PIX_W-1:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = PAL_BLACK;
      3'd1:    palette = PAL_BLUE;
      3'd2:    palette = PAL_RED;
      3'd3:    palette = PAL_PURPLE;
      3'd4:    palette = PAL_GREEN;
      3'd5:    palette = PAL_CYAN;
      3'd6:    palette = PAL_YELLOW;
      default: palette = PAL_WHITE;
    endcase
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// One axis of the bouncing box: position plus direction, advanced once per
// frame start. Ports: Clk, Reset_n (async, active low), Adv (frame start),
// pos (registered position), pos_nxt_c (position after the pending advance).
module vga_box_mover
  import vga_pattern_pkg::*;
#(
  parameter int unsigned MAX  = 736,
  parameter int unsigned STEP = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Adv,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] pos_nxt_c
);

  localparam int unsigned EXT_W = CNT_W + 1;

  dir_e dir;
  dir_e dir_nxt;

  // State register: position and direction.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos <= '0;
      dir <= DIR_INC;
    end else if (Adv) begin
      pos <= pos_nxt_c;
      dir <= dir_nxt;
    end
  end

  // Bounce rule: clamp at the wall and reverse on the same frame.
  always_comb begin
    pos_nxt_c = pos;
    dir_nxt   = dir;
    case (dir)
      DIR_INC: begin
        if ((EXT_W'(pos) + EXT_W'(STEP)) > EXT_W'(MAX)) begin
          pos_nxt_c = CNT_W'(MAX);
          dir_nxt   = DIR_DEC;
        end else begin
          pos_nxt_c = pos + CNT_W'(STEP);
        end
      end
      DIR_DEC: begin
        if (pos < CNT_W'(STEP)) begin
          pos_nxt_c = '0;
          dir_nxt   = DIR_INC;
        end else begin
          pos_nxt_c = pos - CNT_W'(STEP);
        end
      end
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source answering VGA_CTRL's early Data_Req with a
// registered RGB888 pixel (grid, checker, ramp, bouncing box).
// Ports: Clk, Reset_n (async, active low), Data_Req, hcount, vcount, Mode in;
// DATA (pixel), Frame_Cnt (frames started), Mode_Act (pattern in effect) out.
// Build option: define VGA_PATTERN_BOX_EN to compile the bouncing box;
// without it mode 3 emits black.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int unsigned H_ACT    = 800,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 2,
  parameter int unsigned CHK_LOG2 = 5,
  parameter int unsigned BOX      = 64,
  parameter int unsigned STEP     = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Data_Req,
  input  logic [CNT_W-1:0]  hcount,
  input  logic [CNT_W-1:0]  vcount,
  input  logic [MODE_W-1:0] Mode,
  output logic [PIX_W-1:0]  DATA,
  output logic [FCNT_W-1:0] Frame_Cnt,
  output logic [MODE_W-1:0] Mode_Act
);

  localparam int unsigned CW    = H_ACT / COLS;
  localparam int unsigned CH    = V_ACT / ROWS;
  localparam int unsigned EXT_W = CNT_W + 1;

  // Elaboration-time parameter sanity.
  if (ROWS < 1 || COLS < 1) begin : g_bad_grid
    $error("ROWS and COLS must be at least 1");
  end
  if (BOX >= V_ACT || BOX >= H_ACT) begin : g_bad_box
    $error("BOX must be smaller than the active area");
  end
  if (STEP < 1) begin : g_bad_step
    $error("STEP must be at least 1");
  end
  if (CHK_LOG2 >= CNT_W) begin : g_bad_chk
    $error("CHK_LOG2 out of range");
  end

  logic              fs_c;
  logic [MODE_W-1:0] mode_c;
  logic              in_act_c;
  logic [CNT_W-1:0]  col_c;
  logic [CNT_W-1:0]  row_c;
  logic [2:0]        grid_idx_c;
  rgb_t              pix_c;

  assign fs_c     = Data_Req && (hcount == '0) && (vcount == '0);
  // The frame-start pixel already uses the newly latched mode.
  assign mode_c   = fs_c ? Mode : Mode_Act;
  assign in_act_c = (hcount < CNT_W'(H_ACT)) && (vcount < CNT_W'(V_ACT));

  // Cell index by compare chain; last column/row absorb the remainder.
  always_comb begin
    col_c = '0;
    row_c = '0;
    for (int unsigned k = 1; k < COLS; k++) begin
      if (hcount >= CNT_W'(k * CW)) col_c = CNT_W'(k);
    end
    for (int unsigned k = 1; k < ROWS; k++) begin
      if (vcount >= CNT_W'(k * CH)) row_c = CNT_W'(k);
    end
  end

  assign grid_idx_c = 3'((row_c * COLS) + col_c);

`ifdef VGA_PATTERN_BOX_EN
  logic [CNT_W-1:0] bx_q, bx_n, by_q, by_n, bx_c, by_c;
  logic             box_hit_c;

  vga_box_mover #(.MAX(H_ACT - BOX), .STEP(STEP)) u_box_x (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Adv       (fs_c),
    .pos       (bx_q),
    .pos_nxt_c (bx_n)
  );

  vga_box_mover #(.MAX(V_ACT - BOX), .STEP(STEP)) u_box_y (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Adv       (fs_c),
    .pos       (by_q),
    .pos_nxt_c (by_n)
  );

  // On the frame-start cycle the box is drawn at its advanced position.
  assign bx_c = fs_c ? bx_n : bx_q;
  assign by_c = fs_c ? by_n : by_q;

  assign box_hit_c = (hcount >= bx_c) && (EXT_W'(hcount) < (EXT_W'(bx_c) + EXT_W'(BOX))) &&
                     (vcount >= by_c) && (EXT_W'(vcount) < (EXT_W'(by_c) + EXT_W'(BOX)));
`endif

  // Pattern mux.
  always_comb begin
    pix_c = BLACK;
    case (mode_c)
      MODE_GRID: pix_c = palette(grid_idx_c);
      MODE_CHK:  pix_c = (hcount[CHK_LOG2] ^ vcount[CHK_LOG2]) ? WHITE : BLACK;
      MODE_RAMP: pix_c = '{r: hcount[7:0], g: hcount[7:0], b: hcount[7:0]};
`ifdef VGA_PATTERN_BOX_EN
      MODE_BOX:  pix_c = box_hit_c ? WHITE : BLUE;
`else
      MODE_BOX:  pix_c = BLACK;
`endif
    endcase
  end

  // Output register, mode latch and frame counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DATA      <= '0;
      Frame_Cnt <= '0;
      Mode_Act  <= MODE_GRID;
    end else begin
      if (fs_c) begin
        Mode_Act  <= Mode;
        Frame_Cnt <= Frame_Cnt + FCNT_W'(1);
      end
      DATA <= (Data_Req && in_act_c) ? pix_c : BLACK;
    end
  end

endmodule
